// File: rtl/tlul_adapter_reg_lite.sv
// Single-outstanding TL-UL device adapter: turns each buffered A-channel request
// into a one-shot register read/write strobe and returns the result on the D channel.
module tlul_adapter_reg_lite #(
    parameter int RegAw = 8,
    parameter int RegDw = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [101:0]     tl_i,
    output logic [67:0]      tl_o,
    output logic             re_o,
    output logic             we_o,
    output logic [RegAw-1:0] addr_o,
    output logic [RegDw-1:0] wdata_o,
    output logic [3:0]       be_o,
    input  logic [RegDw-1:0] rdata_i,
    input  logic             busy_i,
    input  logic             error_i
);

    localparam logic [2:0] PutFullData    = 3'd0;
    localparam logic [2:0] PutPartialData = 3'd1;
    localparam logic [2:0] Get            = 3'd4;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_e;

    state_e state_q, state_d;

    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_ready;
    logic        unused_tl;

    assign a_valid   = tl_i[101];
    assign a_opcode  = tl_i[100:98];
    assign a_size    = tl_i[94:93];
    assign a_source  = tl_i[92:85];
    assign a_address = tl_i[84:53];
    assign a_mask    = tl_i[52:49];
    assign a_data    = tl_i[48:17];
    assign d_ready   = tl_i[0];
    assign unused_tl = ^{tl_i[97:95], tl_i[16:1], a_address};

    logic             is_get_q;
    logic [1:0]       size_q;
    logic [7:0]       source_q;
    logic [RegDw-1:0] d_data_q;
    logic             d_error_q;
    logic             req_err;
    logic             accept;
    logic             complete;

    // Malformed requests are answered locally and never reach the register side.
    assign req_err = !(a_opcode == PutFullData || a_opcode == PutPartialData || a_opcode == Get)
                   || (a_address[1:0] != 2'b00)
                   || (a_size > 2'd2)
                   || (a_opcode == PutFullData && a_mask != 4'hF);

    assign accept   = (state_q == IDLE) && a_valid;
    assign complete = (state_q == ACCESS) && !busy_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (a_valid) state_d = req_err ? RESP : ACCESS;
            ACCESS:  if (!busy_i) state_d = RESP;
            RESP:    if (d_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            is_get_q  <= 1'b0;
            size_q    <= '0;
            source_q  <= '0;
            addr_o    <= '0;
            be_o      <= '0;
            wdata_o   <= '0;
            d_data_q  <= '0;
            d_error_q <= 1'b0;
        end else if (accept) begin
            is_get_q  <= (a_opcode == Get);
            size_q    <= a_size;
            source_q  <= a_source;
            addr_o    <= a_address[RegAw-1:0] & ~RegAw'(3);
            be_o      <= a_mask;
            wdata_o   <= a_data;
            d_data_q  <= req_err ? '1 : '0;
            d_error_q <= req_err;
        end else if (complete) begin
            // Read data only matters for Get; writes answer with zero unless the register errored.
            d_data_q  <= error_i ? '1 : (is_get_q ? rdata_i : '0);
            d_error_q <= error_i;
        end
    end

    logic d_valid;

    assign d_valid = (state_q == RESP);
    assign re_o    = (state_q == ACCESS) && is_get_q;
    assign we_o    = (state_q == ACCESS) && !is_get_q;

    assign tl_o = {
        d_valid,
        d_valid ? {2'b00, is_get_q} : 3'd0,
        3'd0,
        d_valid ? size_q : 2'd0,
        d_valid ? source_q : 8'd0,
        1'b0,
        d_valid ? d_data_q : 32'd0,
        16'd0,
        d_valid & d_error_q,
        (state_q == IDLE)
    };

endmodule

// File: tb/tb_tlul_adapter_reg_lite.sv
// Self-checking bench for tlul_adapter_reg_lite: directed test-plan scenarios followed
// by randomized requests checked against a transaction-level response model.
module tb_tlul_adapter_reg_lite;

    localparam int RegAw = 8;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic [101:0]     tl_i;
    logic [67:0]      tl_o;
    logic             re_o;
    logic             we_o;
    logic [RegAw-1:0] addr_o;
    logic [31:0]      wdata_o;
    logic [3:0]       be_o;
    logic [31:0]      rdata_i;
    logic             busy_i;
    logic             error_i;

    logic        aValid;
    logic [2:0]  aOpcode;
    logic [2:0]  aParam;
    logic [1:0]  aSize;
    logic [7:0]  aSource;
    logic [31:0] aAddress;
    logic [3:0]  aMask;
    logic [31:0] aData;
    logic [15:0] aUser;
    logic        dReady;

    int checks = 0;
    int errors = 0;

    assign tl_i = {aValid, aOpcode, aParam, aSize, aSource, aAddress, aMask, aData, aUser, dReady};

    tlul_adapter_reg_lite #(.RegAw(RegAw), .RegDw(32)) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .tl_i    (tl_i),
        .tl_o    (tl_o),
        .re_o    (re_o),
        .we_o    (we_o),
        .addr_o  (addr_o),
        .wdata_o (wdata_o),
        .be_o    (be_o),
        .rdata_i (rdata_i),
        .busy_i  (busy_i),
        .error_i (error_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic bit isLegal(input logic [2:0] op, input logic [31:0] addr,
                                   input logic [1:0] size, input logic [3:0] mask);
        return (op == 3'd0 || op == 3'd1 || op == 3'd4) && (addr % 4 == 0) && (size <= 2)
               && !(op == 3'd0 && mask != 4'hF);
    endfunction

    // Whole packed D-channel word the host should see while the response is pending.
    function automatic logic [67:0] expectedResp(input logic [2:0] op, input logic [1:0] size,
                                                 input logic [7:0] source, input bit legal,
                                                 input logic [31:0] rdata, input bit err);
        bit          failed;
        logic [31:0] data;
        failed = !legal || err;
        data   = failed ? 32'hFFFF_FFFF : ((op == 3'd4) ? rdata : 32'h0);
        return {1'b1, (op == 3'd4) ? 3'd1 : 3'd0, 3'd0, size, source, 1'b0, data, 16'h0, failed, 1'b0};
    endfunction

    // Runs one full transaction starting at a negedge with the adapter idle, ends at the
    // negedge after the D handshake. holdNext keeps a_valid up during the response.
    task automatic applyStimulus(input logic [2:0] op, input logic [1:0] size, input logic [7:0] source,
                                 input logic [31:0] addr, input logic [3:0] mask, input logic [31:0] data,
                                 input int busyCycles, input logic [31:0] rdata, input bit err,
                                 input int readyDelay, input bit holdNext);
        bit          legal;
        logic [67:0] expResp;
        legal   = isLegal(op, addr, size, mask);
        expResp = expectedResp(op, size, source, legal, rdata, err);

        aValid   = 1'b1;
        aOpcode  = op;
        aSize    = size;
        aSource  = source;
        aAddress = addr;
        aMask    = mask;
        aData    = data;
        aParam   = 3'($urandom);
        aUser    = 16'($urandom);
        dReady   = 1'b0;
        busy_i   = 1'b0;
        error_i  = 1'b0;
        checkOutput("a_ready_idle", tl_o[0], 1'b1);
        @(negedge clk_i);
        aValid = 1'b0;

        if (legal) begin
            for (int k = 0; k <= busyCycles; k++) begin
                busy_i  = (k < busyCycles);
                rdata_i = (k < busyCycles) ? $urandom : rdata;
                error_i = (k < busyCycles) ? 1'($urandom) : err;
                checkOutput("re_o_access", re_o, op == 3'd4);
                checkOutput("we_o_access", we_o, op != 3'd4);
                checkOutput("addr_o", addr_o, addr[RegAw-1:0]);
                checkOutput("be_o", be_o, mask);
                checkOutput("wdata_o", wdata_o, data);
                checkOutput("tl_o_access_idle_d", {tl_o[67], tl_o[0]}, 2'b00);
                @(negedge clk_i);
            end
            busy_i  = 1'b0;
            error_i = 1'b0;
            rdata_i = $urandom;
        end

        for (int k = 0; k <= readyDelay; k++) begin
            dReady = (k == readyDelay);
            if (holdNext) aValid = 1'b1;
            checkOutput("d_resp", tl_o, expResp);
            checkOutput("strobes_in_resp", {re_o, we_o}, 2'b00);
            @(negedge clk_i);
        end
        dReady = 1'b0;
        aValid = 1'b0;
        checkOutput("a_ready_after_d", tl_o[0], 1'b1);
        checkOutput("d_valid_after_d", tl_o[67], 1'b0);
    endtask

    initial begin
        logic [2:0]  op;
        logic [31:0] addr;
        logic [1:0]  size;
        logic [3:0]  mask;

        rst_i    = 1'b1;
        aValid   = 1'b0;
        aOpcode  = '0;
        aParam   = '0;
        aSize    = '0;
        aSource  = '0;
        aAddress = '0;
        aMask    = '0;
        aData    = '0;
        aUser    = '0;
        dReady   = 1'b0;
        rdata_i  = '0;
        busy_i   = 1'b0;
        error_i  = 1'b0;
        repeat (2) @(negedge clk_i);
        checkOutput("reset_tl_o", tl_o, 68'h1);
        checkOutput("reset_strobes", {re_o, we_o}, 2'b00);
        checkOutput("reset_regside", {addr_o, wdata_o, be_o}, '0);
        rst_i = 1'b0;
        @(negedge clk_i);

        $display("[TB] directed: Get, PutPartial with busy, illegal requests, register error");
        applyStimulus(3'd4, 2'd2, 8'h5A, 32'hA5A5_0008, 4'hF, 32'h0, 0, 32'hDEAD_BEEF, 1'b0, 0, 1'b0);
        applyStimulus(3'd1, 2'd2, 8'h11, 32'h0000_0014, 4'b0011, 32'h1234_5678, 3, 32'h0BAD_F00D, 1'b0, 0, 1'b0);
        applyStimulus(3'd2, 2'd2, 8'h21, 32'h0000_0020, 4'hF, 32'h5555_AAAA, 0, 32'h0, 1'b0, 0, 1'b0);
        applyStimulus(3'd4, 2'd2, 8'h22, 32'hFFFF_FF02, 4'hF, 32'h0, 0, 32'h0, 1'b0, 0, 1'b0);
        applyStimulus(3'd0, 2'd2, 8'h23, 32'h0000_0030, 4'h7, 32'hCAFE_F00D, 0, 32'h0, 1'b0, 1, 1'b0);
        applyStimulus(3'd4, 2'd2, 8'h24, 32'h0000_0040, 4'hF, 32'h0, 1, 32'h1357_9BDF, 1'b1, 0, 1'b0);

        $display("[TB] directed: D backpressure with a waiting request");
        applyStimulus(3'd4, 2'd1, 8'h30, 32'h0000_0044, 4'hF, 32'h0, 0, 32'h2468_ACE0, 1'b0, 10, 1'b1);
        applyStimulus(3'd0, 2'd2, 8'h31, 32'h0000_0048, 4'hF, 32'hFEED_FACE, 0, 32'h0, 1'b0, 0, 1'b0);

        $display("[TB] directed: reset during ACCESS");
        aValid   = 1'b1;
        aOpcode  = 3'd4;
        aSize    = 2'd2;
        aSource  = 8'h33;
        aAddress = 32'h0000_0010;
        aMask    = 4'hF;
        dReady   = 1'b1;
        busy_i   = 1'b1;
        @(negedge clk_i);
        aValid = 1'b0;
        checkOutput("re_o_before_reset", re_o, 1'b1);
        #2 rst_i = 1'b1;
        #1;
        checkOutput("strobes_async_reset", {re_o, we_o}, 2'b00);
        checkOutput("tl_o_async_reset", tl_o, 68'h1);
        checkOutput("addr_o_async_reset", addr_o, '0);
        @(negedge clk_i);
        rst_i  = 1'b0;
        busy_i = 1'b0;
        repeat (3) begin
            @(negedge clk_i);
            checkOutput("no_response_after_reset", tl_o, 68'h1);
        end
        dReady = 1'b0;
        applyStimulus(3'd4, 2'd2, 8'h34, 32'h0000_0010, 4'hF, 32'h0, 0, 32'h7777_1111, 1'b0, 0, 1'b0);

        $display("[TB] randomized transactions");
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                op = 3'($urandom);
            end else begin
                case ($urandom_range(0, 2))
                    0:       op = 3'd0;
                    1:       op = 3'd1;
                    default: op = 3'd4;
                endcase
            end
            addr = $urandom;
            if ($urandom_range(0, 3) != 0) addr[1:0] = 2'b00;
            size = ($urandom_range(0, 4) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            mask = (op == 3'd0 && $urandom_range(0, 3) != 0) ? 4'hF : 4'($urandom);
            applyStimulus(op, size, 8'($urandom), addr, mask, $urandom, $urandom_range(0, 3),
                          $urandom, ($urandom_range(0, 7) == 0), $urandom_range(0, 3),
                          1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tlul_adapter_reg_lite.md
# tlul_adapter_reg_lite

Single-outstanding TL-UL device adapter that sits directly downstream of a `tlul_fifo_sync` request/response buffer. It consumes the buffered A channel and converts each request into a one-shot register read or write strobe. It captures the register-side result and returns a D-channel response through the FIFO's response path. Malformed requests are answered locally with `d_error`, and no register access is issued for them.

## Interface
- `RegAw`, default 8: register address width; must be ≥ 2.
- `RegDw`, fixed 32: register data width; equals TL_DW.
- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset; asynchronous, active-high.
- `tl_i`  in  102  host-to-device packed bus:
  - `a_valid[101]`, `a_opcode[100:98]`, `a_param[97:95]`, `a_size[94:93]`.
  - `a_source[92:85]`, `a_address[84:53]`, `a_mask[52:49]`, `a_data[48:17]`.
  - `a_user[16:1]`, `d_ready[0]`.
- `tl_o`  out  68  device-to-host packed bus:
  - `d_valid[67]`, `d_opcode[66:64]`, `d_param[63:61]`, `d_size[60:59]`.
  - `d_source[58:51]`, `d_sink[50]`, `d_data[49:18]`, `d_user[17:2]`.
  - `d_error[1]`, `a_ready[0]`.
- `re_o`  out  1  register read strobe.
- `we_o`  out  1  register write strobe.
- `addr_o`  out  RegAw  word-aligned register address; bits [1:0] are always 0.
- `wdata_o`  out  32  write data.
- `be_o`  out  4  byte enables.
- `rdata_i`  in  32  read data; sampled in the completion cycle.
- `busy_i`  in  1  register side not ready; extends the access.
- `error_i`  in  1  register-side error; sampled in the completion cycle.

## Operation
- FSM states: IDLE, ACCESS, RESP. Reset state is IDLE.
- `a_ready = (state == IDLE)`. There is no other gating.
- IDLE, with `a_valid`: the request is accepted. Capture `a_opcode`, `a_size`, `a_source`, `a_address[RegAw-1:0]`, `a_mask` and `a_data`. Then check the request for errors:
  - The request is an error if any of these hold:
    - opcode is not in {PutFullData=0, PutPartialData=1, Get=4};
    - `a_address[1:0] != 0`;
    - `a_size > 2`;
    - opcode is PutFullData and `a_mask != 4'hF`.
  - Error request: go to RESP with `d_error=1` and `d_data=32'hFFFF_FFFF`. Skip ACCESS; no strobe is issued.
  - Valid request: go to ACCESS.
- ACCESS:
  - `re_o=1` for Get; `we_o=1` for Put.
  - `addr_o`, `wdata_o` and `be_o` are driven from the captured values and held stable for the whole state.
  - Completion is the first ACCESS cycle with `busy_i=0`. In that cycle, capture `rdata_i` (Get only; Put returns `d_data=0`) and `error_i`, then go to RESP.
  - If `error_i` is captured: `d_error=1` and `d_data=32'hFFFF_FFFF`. The write is still considered issued.
- RESP:
  - `d_valid=1`.
  - `d_opcode` is AccessAckData (1) for Get and AccessAck (0) for Put. An illegal-opcode error also returns AccessAck.
  - `d_param=0`, `d_size` = captured `a_size`, `d_source` = captured `a_source`, `d_sink=0`, `d_user=0`.
  - All D fields stay stable until the handshake. On `d_ready`, go to IDLE.
- `a_param` and `a_user` are ignored.
- With `re_o` and `we_o` both low, `addr_o`, `wdata_o` and `be_o` hold their last values. They are don't-care.

## Timing
- Reset values:
  - `tl_o`: `a_ready=1`; every other field is 0.
  - `re_o=0`, `we_o=0`, `addr_o=0`, `wdata_o=0`, `be_o=0`.
- The A handshake occurs in cycle N.
- Valid request:
  - ACCESS is in cycle N+1, with the strobe high.
  - With `busy_i` held low, the strobe is high for exactly 1 cycle and `d_valid` rises at N+2.
  - Each `busy_i=1` cycle adds one cycle, and the strobe stays high for those cycles.
- Error request: `d_valid` rises at N+1.
- The D handshake in cycle M returns the FSM to IDLE. `a_ready=1` at M+1, so the next accept is at M+1 at the earliest; there is no same-cycle turnaround.
  - Peak throughput is 1 transaction per 3 cycles with `d_ready` tied high.
- `d_ready` low holds RESP indefinitely. `a_ready` stays 0 throughout.
- Reset asserted mid-ACCESS or mid-RESP: the FSM returns to IDLE immediately and all outputs take their reset values. The transaction is dropped with no response.

## Test plan
- Get with `a_address=0x...08`, `a_source=0x5A`, `rdata_i=0xDEADBEEF`, `busy_i=0`:
  - `re_o` is high for one cycle at N+1 with `addr_o=0x08`.
  - At N+2: `d_valid=1`, `d_opcode=1`, `d_data=0xDEADBEEF`, `d_source=0x5A`, `d_error=0`.
- PutPartial with `a_mask=4'b0011`, `a_data=0x12345678`, `busy_i` high for 3 cycles:
  - `we_o` is high for 4 cycles with `be_o=3`.
  - `d_valid` at N+5 with `d_opcode=0` and `d_data=0`.
- Illegal requests, each sent separately: `a_opcode=2`; a misaligned address (0x...02); PutFull with mask `4'h7`.
  - `re_o` and `we_o` never assert.
  - Each gives `d_valid` at N+1 with `d_error=1` and `d_data=0xFFFFFFFF`.
- Get with `error_i=1` at completion: `d_error=1`, `d_data=0xFFFFFFFF`, `d_opcode=1`.
- Backpressure with `d_ready=0` for 10 cycles:
  - `d_valid` and all D fields stay stable, and `a_ready=0`.
  - A new request held on `a_valid` is not accepted until the cycle after `d_ready=1`.
- Reset pulse during ACCESS:
  - `re_o` and `we_o` drop asynchronously and no `d_valid` follows.
  - After release `a_ready=1`, and the next Get completes normally.
